dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache that answers the EX-stage load/store request (`ex_req_Dcache`, address, width, rw, write data, read type) and fronts a simple word-wide memory bus. Load hits return data combinationally in the request cycle. Misses and all stores assert `dcache_stall_o` toward the flow controller until the response cycle. The block sits between EX/MEM and the data memory.

---
 rtl/dcache.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
`default_nettype none
// ============================================================================
// Module   : dcache
// Purpose  : Direct-mapped, write-through, no-write-allocate L1 data cache.
// Revision : 1.0
// ============================================================================
module dcache #(
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_req_Dcache_i,
    input  logic        ex_mem_rw_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic [1:0]  ex_mem_wrwidth_i,
    input  logic [31:0] ex_mem_wr_data_i,
    input  logic        ex_mem_rdtype_i,
    output logic [31:0] dcache_rd_data_o,
    output logic        dcache_ready_o,
    output logic        dcache_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 32 - 4 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        width_q;
    logic              rw_q;
    logic              rdtype_q;
    logic [1:0]        beat;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES*4];

    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [1:0]         req_off;
    logic [INDEX_W-1:0] idx_q;
    logic               hit;
    logic               active;
    logic               load_hit;
    logic               start_miss;
    logic               start_store;
    logic [31:0]        hit_word;
    logic [31:0]        merged_word;
    logic [3:0]         req_strb;
    logic [31:0]        req_wdata;

    function automatic logic [3:0] make_strb(input logic [1:0] width, input logic [1:0] lo);
        case (width)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] make_wdata(input logic [1:0] width, input logic [31:0] d);
        case (width)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] width,
                                            input logic [1:0] lo, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (width)
            2'b00:   return zext ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   return zext ? {16'd0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    assign req_idx = ex_mem_addr_i[4+INDEX_W-1:4];
    assign req_tag = ex_mem_addr_i[31:4+INDEX_W];
    assign req_off = ex_mem_addr_i[3:2];
    assign idx_q   = addr_q[4+INDEX_W-1:4];

    // Request-side decode is gated by rst_n so a held request cannot stall during reset.
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign active      = ex_req_Dcache_i && rst_n && (state == IDLE);
    assign load_hit    = active && !ex_mem_rw_i && hit;
    assign start_miss  = active && !ex_mem_rw_i && !hit;
    assign start_store = active && ex_mem_rw_i;

    assign hit_word  = data_mem[{req_idx, req_off}];
    assign req_strb  = make_strb(ex_mem_wrwidth_i, ex_mem_addr_i[1:0]);
    assign req_wdata = make_wdata(ex_mem_wrwidth_i, ex_mem_wr_data_i);

    always_comb begin
        merged_word = hit_word;
        for (int i = 0; i < 4; i++) begin
            if (req_strb[i]) begin
                merged_word[i*8 +: 8] = req_wdata[i*8 +: 8];
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (start_miss) begin
            tag_mem[req_idx] <= req_tag;
        end
        if (start_store && hit) begin
            data_mem[{req_idx, req_off}] <= merged_word;
        end
        if (state == REFILL && mem_ack_i) begin
            data_mem[{idx_q, beat}] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            width_q  <= '0;
            rw_q     <= 1'b0;
            rdtype_q <= 1'b0;
            beat     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_miss || start_store) begin
                        addr_q   <= ex_mem_addr_i;
                        wdata_q  <= ex_mem_wr_data_i;
                        width_q  <= ex_mem_wrwidth_i;
                        rw_q     <= ex_mem_rw_i;
                        rdtype_q <= ex_mem_rdtype_i;
                        beat     <= 2'd0;
                    end
                    if (start_miss) begin
                        valid[req_idx] <= 1'b0;
                        state          <= REFILL;
                    end else if (start_store) begin
                        state <= WRITE;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        beat <= beat + 2'd1;
                        if (beat == 2'd3) begin
                            valid[idx_q] <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem_req_o        = 1'b0;
        mem_we_o         = 1'b0;
        mem_addr_o       = 32'd0;
        mem_wdata_o      = 32'd0;
        mem_wstrb_o      = 4'd0;
        dcache_ready_o   = 1'b0;
        dcache_stall_o   = start_miss || start_store;
        dcache_rd_data_o = 32'd0;
        case (state)
            REFILL: begin
                mem_req_o      = 1'b1;
                mem_addr_o     = {addr_q[31:4], beat, 2'b00};
                dcache_stall_o = 1'b1;
            end
            WRITE: begin
                mem_req_o      = 1'b1;
                mem_we_o       = 1'b1;
                mem_addr_o     = {addr_q[31:2], 2'b00};
                mem_wdata_o    = make_wdata(width_q, wdata_q);
                mem_wstrb_o    = make_strb(width_q, addr_q[1:0]);
                dcache_stall_o = 1'b1;
            end
            RESP: begin
                dcache_ready_o = 1'b1;
                if (!rw_q) begin
                    dcache_rd_data_o = extract(data_mem[{idx_q, addr_q[3:2]}], width_q,
                                               addr_q[1:0], rdtype_q);
                end
            end
            default: begin
                if (load_hit) begin
                    dcache_ready_o   = 1'b1;
                    dcache_rd_data_o = extract(hit_word, ex_mem_wrwidth_i,
                                               ex_mem_addr_i[1:0], ex_mem_rdtype_i);
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache
// Purpose  : Self-checking bench for dcache with a wait-state memory model.
// Revision : 1.0
// ============================================================================
module tb_dcache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wr_data;
    logic        rdtype;
    logic [31:0] rd_data;
    logic        ready;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dcache #(.INDEX_W(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_req_Dcache_i  (req),
        .ex_mem_rw_i      (rw),
        .ex_mem_addr_i    (addr),
        .ex_mem_wrwidth_i (width),
        .ex_mem_wr_data_i (wr_data),
        .ex_mem_rdtype_i  (rdtype),
        .dcache_rd_data_o (rd_data),
        .dcache_ready_o   (ready),
        .dcache_stall_o   (stall),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_wstrb_o      (mem_wstrb),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata)
    );

    // Memory model: word i holds 0x10000000|i except the line at 0x100.
    logic [31:0] bmem [0:4095];
    bit          mem_init = 1'b0;
    int          waits = 0;
    int          wcnt = 0;

    assign mem_ack   = mem_req && (wcnt >= waits);
    assign mem_rdata = bmem[mem_addr[13:2]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 4096; i++) bmem[i] <= 32'h1000_0000 | 32'(i);
            bmem[64] <= 32'h1111_1111;
            bmem[65] <= 32'h2222_2222;
            bmem[66] <= 32'h3333_3333;
            bmem[67] <= 32'h80FF_7F01;
            mem_init <= 1'b1;
        end else if (mem_req && mem_ack && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) bmem[mem_addr[13:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
    end

    typedef struct {
        logic        rw;
        logic [1:0]  width;
        logic        rdtype;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_data;
        int          exp_beats;
        int          exp_cyc;
        logic [31:0] exp_baddr;
        logic [31:0] exp_bwdata;
        logic [3:0]  exp_bwstrb;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } beat_t;

    vec_t        vecs[$];
    beat_t       bus_q[$];
    logic [31:0] resp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          nbeats;

    function automatic vec_t mk(logic r, logic [1:0] w, logic rt, logic [31:0] a, logic [31:0] d,
                                int wt, logic [31:0] ed, int eb, int ec,
                                logic [31:0] ba, logic [31:0] bd, logic [3:0] bs);
        vec_t v;
        v.rw = r; v.width = w; v.rdtype = rt; v.addr = a; v.wdata = d; v.waits = wt;
        v.exp_data = ed; v.exp_beats = eb; v.exp_cyc = ec;
        v.exp_baddr = ba; v.exp_bwdata = bd; v.exp_bwstrb = bs;
        return v;
    endfunction

    task automatic check_bus();
        beat_t e;
        if (mem_req && mem_ack) begin
            nbeats++;
            checks++;
            if (bus_q.size() == 0) begin
                failures++;
                $display("FAIL bus_beat unexpected: we=%0b addr=%h required none", mem_we, mem_addr);
            end else begin
                e = bus_q.pop_front();
                if (mem_we !== e.we || mem_addr !== e.addr ||
                    (e.we && (mem_wdata !== e.wdata || mem_wstrb !== e.wstrb))) begin
                    failures++;
                    $display("FAIL bus_beat: got we=%0b addr=%h wdata=%h strb=%b required we=%0b addr=%h wdata=%h strb=%b",
                             mem_we, mem_addr, mem_wdata, mem_wstrb, e.we, e.addr, e.wdata, e.wstrb);
                end
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  cyc;
        bit  done;
        bit  stall_bad;
        beat_t e;
        logic [31:0] exp;
        @(posedge clk); #1;
        waits = v.waits; req = 1'b1; rw = v.rw; addr = v.addr; width = v.width;
        wr_data = v.wdata; rdtype = v.rdtype;
        if (v.exp_beats == 4) begin
            for (int k = 0; k < 4; k++) begin
                e.we = 1'b0; e.addr = {v.addr[31:4], 4'b0000} + 32'(4 * k); e.wdata = '0; e.wstrb = '0;
                bus_q.push_back(e);
            end
        end else if (v.exp_beats == 1) begin
            e.we = 1'b1; e.addr = v.exp_baddr; e.wdata = v.exp_bwdata; e.wstrb = v.exp_bwstrb;
            bus_q.push_back(e);
        end
        if (!v.rw) resp_q.push_back(v.exp_data);
        cyc = 0; done = 1'b0; stall_bad = 1'b0; nbeats = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            check_bus();
            if (ready) begin
                done = 1'b1;
                if (stall) stall_bad = 1'b1;
                if (!v.rw) begin
                    exp = resp_q.pop_front();
                    checks++;
                    if (rd_data !== exp) begin
                        failures++;
                        $display("FAIL load_data @%h: got %h required %h", v.addr, rd_data, exp);
                    end
                end
            end else begin
                if (!stall) stall_bad = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
        end
        checks++;
        if (!done || cyc != v.exp_cyc) begin
            failures++;
            $display("FAIL latency @%h: got %0d (done=%0b) required %0d", v.addr, cyc, done, v.exp_cyc);
        end
        checks++;
        if (nbeats != v.exp_beats) begin
            failures++;
            $display("FAIL bus_beats @%h: got %0d required %0d", v.addr, nbeats, v.exp_beats);
        end
        checks++;
        if (stall_bad) begin
            failures++;
            $display("FAIL stall_shape @%h: got irregular stall required high until ready", v.addr);
        end
        bus_q.delete();
        resp_q.delete();
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (ready || stall || mem_req) begin
            failures++;
            $display("FAIL idle_quiet @%h: got ready=%0b stall=%0b req=%0b required 0/0/0",
                     v.addr, ready, stall, mem_req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        beat_t e;
        rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; width = '0; wr_data = '0; rdtype = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rd_data !== 32'd0 || ready || stall || mem_req || mem_we ||
            mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: got rd=%h rdy=%0b st=%0b req=%0b required all 0",
                     rd_data, ready, stall, mem_req);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        //            rw    w      rt    addr           wdata          wt exp_data       bt cyc bus addr/data/strb
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         0, 32'h1111_1111, 4, 5,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_010C, 32'h0,         0, 32'h0000_0001, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_010D, 32'h0,         0, 32'h0000_007F, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_010E, 32'h0,         0, 32'hFFFF_FFFF, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_010E, 32'h0,         0, 32'h0000_80FF, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_010E, 32'h0,         0, 32'hFFFF_80FF, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h0000_BEEF, 0, 32'h0,         1, 2,
                          32'h0000_0104, 32'hBEEF_BEEF, 4'b1100));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,         0, 32'hBEEF_2222, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b1, 32'h0000_2001, 32'h0000_00AA, 0, 32'h0,         1, 2,
                          32'h0000_2000, 32'hAAAA_AAAA, 4'b0010));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0,         0, 32'h0000_00AA, 4, 5,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0,         0, 32'h1000_0080, 4, 5,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,         2, 32'h1111_1111, 4, 13, 0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0,         2, 32'hBEEF_2222, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0108, 32'h1234_5678, 1, 32'h0,         1, 3,
                          32'h0000_0108, 32'h1234_5678, 4'b1111));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_010A, 32'h0,         0, 32'h0000_1234, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0108, 32'h0,         0, 32'h0000_5678, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_010F, 32'h0000_009C, 0, 32'h0,         1, 2,
                          32'h0000_010C, 32'h9C9C_9C9C, 4'b1000));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_010F, 32'h0,         0, 32'hFFFF_FF9C, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_010C, 32'h0,         0, 32'h9CFF_7F01, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1'b0, 2'b11, 1'b1, 32'h0000_010B, 32'h0,         0, 32'h1234_5678, 0, 0,  0, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a refill, with the request still held.
        @(posedge clk); #1;
        waits = 0; req = 1'b1; rw = 1'b0; addr = 32'h0000_0300; width = 2'b10; rdtype = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.we = 1'b0; e.addr = 32'h0000_0300 + 32'(4 * k); e.wdata = '0; e.wstrb = '0;
            bus_q.push_back(e);
        end
        nbeats = 0;
        for (int c = 0; c < 50 && nbeats < 2; c++) begin
            @(negedge clk);
            check_bus();
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req || stall || ready) begin
            failures++;
            $display("FAIL reset_abort: got req=%0b stall=%0b ready=%0b required 0/0/0", mem_req, stall, ready);
        end
        @(negedge clk);
        checks++;
        if (mem_req || stall || ready) begin
            failures++;
            $display("FAIL reset_hold: got req=%0b stall=%0b ready=%0b required 0/0/0", mem_req, stall, ready);
        end
        req = 1'b0;
        bus_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h1000_00C0, 4, 5, 0, 0, 0));
        run_vec(mk(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 0, 32'hBEEF_2222, 4, 5, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
